// File: rtl/pwm_timer_bank.sv
// Bank of independent PWM channels with per-channel modulo-CYCLE counters and period-wrap shadow reload.
// Optional build macro PWM_OUTPUT_MASK_EN adds the per-channel OUT_EN gate.
module pwm_timer_bank #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        SYNC,
  input  logic [DEPTH-1:0][WIDTH-1:0] CYCLE,
  input  logic [DEPTH-1:0][WIDTH-1:0] DUTY,
  input  logic [DEPTH-1:0][WIDTH-1:0] PHASE,
`ifdef PWM_OUTPUT_MASK_EN
  input  logic [DEPTH-1:0]            OUT_EN,
`endif
  output logic [DEPTH-1:0]            PWM_OUT,
  output logic                        UPDATE
);

  logic [DEPTH-1:0][WIDTH-1:0] t_q, t_d;
  logic [DEPTH-1:0][WIDTH-1:0] c_q, c_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [DEPTH-1:0][WIDTH-1:0] p_q, p_d;
  logic [DEPTH-1:0]            pwm_q, pwm_d;
  logic                        update_q, update_d;

  always_comb begin
    logic             wr;
    logic [WIDTH:0]   cx;
    logic [WIDTH:0]   tx;
    logic [WIDTH:0]   pn;
    logic [WIDTH:0]   us;
    logic [WIDTH:0]   um;
    t_d      = t_q;
    c_d      = c_q;
    d_d      = d_q;
    p_d      = p_q;
    pwm_d    = '0;
    update_d = SYNC;
    wr       = 1'b0;
    cx       = '0;
    tx       = '0;
    pn       = '0;
    us       = '0;
    um       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cx = {1'b0, c_q[i]};
      tx = {1'b0, t_q[i]};
      // A zero-length period wraps every cycle, so its shadows track the inputs continuously.
      wr = (c_q[i] == '0) || ((tx + 1'b1) >= cx);
      if (SYNC || wr) begin
        t_d[i] = '0;
        c_d[i] = CYCLE[i];
        d_d[i] = DUTY[i];
        p_d[i] = PHASE[i];
      end else begin
        t_d[i] = t_q[i] + 1'b1;
      end
      if (i == 0) update_d = SYNC || wr;

      pn = ({1'b0, p_q[i]} >= cx) ? ({1'b0, p_q[i]} - cx) : {1'b0, p_q[i]};
      us = tx + cx - pn;
      um = (us >= cx) ? (us - cx) : us;
      pwm_d[i] = (d_q[i] != '0) && (c_q[i] != '0) &&
                 ((d_q[i] >= c_q[i]) || (um < {1'b0, d_q[i]}));
`ifdef PWM_OUTPUT_MASK_EN
      pwm_d[i] = pwm_d[i] & OUT_EN[i];
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      t_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      p_q      <= '0;
      pwm_q    <= '0;
      update_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      c_q      <= c_d;
      d_q      <= d_d;
      p_q      <= p_d;
      pwm_q    <= pwm_d;
      update_q <= update_d;
    end
  end

  assign PWM_OUT = pwm_q;
  assign UPDATE  = update_q;

endmodule

// File: tb/tb_pwm_timer_bank.sv
// Directed self-checking bench for pwm_timer_bank; expected waveforms are hand-written per-period bit patterns.
module tb_pwm_timer_bank;
  localparam int WIDTH = 13;
  localparam int DEPTH = 8;

  logic                        CLK;
  logic                        RST;
  logic                        SYNC;
  logic [DEPTH-1:0][WIDTH-1:0] CYCLE;
  logic [DEPTH-1:0][WIDTH-1:0] DUTY;
  logic [DEPTH-1:0][WIDTH-1:0] PHASE;
  logic [DEPTH-1:0]            OUT_EN;
  logic [DEPTH-1:0]            PWM_OUT;
  logic                        UPDATE;

  int          checks = 0;
  int          errors = 0;
  int          cyc_m [DEPTH];
  logic [15:0] pat_m [DEPTH];
  logic [DEPTH-1:0] mask_exp;

  pwm_timer_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SYNC    (SYNC),
    .CYCLE   (CYCLE),
    .DUTY    (DUTY),
    .PHASE   (PHASE),
`ifdef PWM_OUTPUT_MASK_EN
    .OUT_EN  (OUT_EN),
`endif
    .PWM_OUT (PWM_OUT),
    .UPDATE  (UPDATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_pwm(input string tag, input logic [DEPTH-1:0] exp);
    checks++;
    assert (PWM_OUT === exp) else begin
      errors++;
      $error("FAIL %s pwm observed=%b expected=%b", tag, PWM_OUT, exp);
    end
  endtask

  task automatic chk_upd(input string tag, input logic exp);
    checks++;
    assert (UPDATE === exp) else begin
      errors++;
      $error("FAIL %s update observed=%b expected=%b", tag, UPDATE, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int cyc, input int duty, input int ph, input logic [15:0] pat);
    CYCLE[ch] = WIDTH'(cyc);
    DUTY[ch]  = WIDTH'(duty);
    PHASE[ch] = WIDTH'(ph);
    cyc_m[ch] = cyc;
    pat_m[ch] = pat;
  endtask

  task automatic set_all(input int cyc, input int duty, input int ph, input logic [15:0] pat);
    for (int i = 0; i < DEPTH; i++) set_ch(i, cyc, duty, ph, pat);
  endtask

  task automatic do_sync(input string tag);
    SYNC = 1'b1;
    @(posedge CLK); #1;
    SYNC = 1'b0;
    chk_upd(tag, 1'b1);
  endtask

  // k counts edges since the last SYNC edge; output after edge k reflects tick (k-1) of the period.
  task automatic run_chk(input string tag, input int k0, input int n);
    logic [DEPTH-1:0] exp;
    logic [15:0]      pat;
    int               tp;
    for (int k = k0; k < k0 + n; k++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < DEPTH; i++) begin
        tp     = (k - 1) % cyc_m[i];
        pat    = pat_m[i];
        exp[i] = pat[tp] & mask_exp[i];
      end
      chk_pwm(tag, exp);
      chk_upd(tag, (k % cyc_m[0]) == 0);
    end
  endtask

  initial begin
    RST      = 1'b1;
    SYNC     = 1'b0;
    OUT_EN   = '1;
    mask_exp = '1;
    set_all(10, 4, 0, 16'h000F);

    #2;
    chk_pwm("reset_pwm", '0);
    chk_upd("reset_upd", 1'b0);
    @(posedge CLK); @(posedge CLK); #1;
    chk_pwm("reset_hold_pwm", '0);
    chk_upd("reset_hold_upd", 1'b0);
    RST = 1'b0;

    // basic window t=0..3
    do_sync("sync_a");
    run_chk("c10_d4_p0", 1, 20);

    set_all(10, 4, 3, 16'h0078);
    do_sync("sync_p3");
    run_chk("c10_d4_p3", 1, 20);

    set_all(10, 4, 8, 16'h0303);
    do_sync("sync_p8");
    run_chk("c10_d4_p8_wrap", 1, 20);

    set_all(8, 0, 0, 16'h0000);
    do_sync("sync_d0");
    run_chk("c8_d0", 1, 16);

    set_all(8, 8, 0, 16'h00FF);
    do_sync("sync_d8");
    run_chk("c8_d8", 1, 16);

    set_all(8, 8191, 0, 16'h00FF);
    do_sync("sync_dmax");
    run_chk("c8_d8191", 1, 16);

    // duty change at t=5 must not touch the running period
    set_all(10, 4, 0, 16'h000F);
    do_sync("sync_dchg");
    run_chk("dchg_pre", 1, 5);
    for (int i = 0; i < DEPTH; i++) DUTY[i] = WIDTH'(6);
    run_chk("dchg_cur", 6, 5);
    for (int i = 0; i < DEPTH; i++) pat_m[i] = 16'h003F;
    run_chk("dchg_next", 11, 20);

    // mixed periods, then re-sync mid-period
    set_all(10, 4, 0, 16'h000F);
    set_ch(1, 7, 4, 0, 16'h000F);
    do_sync("sync_mix");
    run_chk("mix_free", 1, 12);
    do_sync("sync_mix2");
    run_chk("mix_resync", 1, 22);

    // async reset in the middle of a high phase
    set_all(10, 4, 0, 16'h000F);
    do_sync("sync_rst");
    run_chk("pre_rst", 1, 2);
    #3;
    RST = 1'b1;
    #1;
    chk_pwm("midrst_pwm", '0);
    chk_upd("midrst_upd", 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // zero period: always low, UPDATE held high
    set_all(0, 4, 0, 16'h0000);
    do_sync("sync_c0");
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      chk_pwm("c0_low", '0);
      chk_upd("c0_upd_level", 1'b1);
    end

    // SYNC held high pins every counter at 0
    set_all(10, 4, 0, 16'h000F);
    SYNC = 1'b1;
    @(posedge CLK); #1;
    chk_upd("synchold_upd", 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk_pwm("synchold_pwm", '1);
      chk_upd("synchold_upd", 1'b1);
    end
    SYNC = 1'b0;
    run_chk("after_synchold", 1, 10);

`ifdef PWM_OUTPUT_MASK_EN
    set_all(10, 4, 0, 16'h000F);
    do_sync("sync_mask");
    run_chk("mask_pre", 1, 5);
    OUT_EN[3]   = 1'b0;
    mask_exp[3] = 1'b0;
    run_chk("mask_off", 6, 25);
    OUT_EN[3]   = 1'b1;
    mask_exp[3] = 1'b1;
    run_chk("mask_on", 31, 20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
